// File: rtl/work_loader.sv
// Work loader between a byte-stream host link and a mining core: frames 96-byte
// work units into 24 words for the core and returns golden nonces to the host.
module work_loader #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        start_found,
  output logic [31:0] in_data,
  output logic        shift_in_enable,
  input  logic        sol_claim,
  input  logic [31:0] nonce_in,
  output logic        sol_response,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int          TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [4:0]  LAST_WORD = 5'd23;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SOL, SEND} state_t;

  state_t          state, state_next;
  logic [1:0]      byte_cnt;
  logic [4:0]      word_cnt;
  logic [TW-1:0]   timer;
  logic [31:0]     acc;
  logic [31:0]     nonce;
  logic [1:0]      tx_cnt;

  logic rx_fire, tx_fire;
  logic restart, word_done, capture, send_done;

  assign rx_ready = (state != SEND);
  assign busy     = (state != IDLE);
  assign tx_valid = (state == SEND);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    word_done  = 1'b0;
    capture    = 1'b0;
    send_done  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_fire && rx_data == SYNC) begin
          restart    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (rx_fire) begin
          if (byte_cnt == 2'd3) begin
            word_done = 1'b1;
            if (word_cnt == LAST_WORD) state_next = WAIT_SOL;
          end
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next = IDLE;
        end
      end
      WAIT_SOL: begin
        // A solution already found outranks new work arriving on the same cycle.
        if (sol_claim) begin
          capture    = 1'b1;
          state_next = SEND;
        end else if (rx_fire && rx_data == SYNC) begin
          restart    = 1'b1;
          state_next = LOAD;
        end
      end
      SEND: begin
        if (tx_fire && tx_cnt == 2'd3) begin
          send_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_found     <= 1'b0;
      shift_in_enable <= 1'b0;
      sol_response    <= 1'b0;
      byte_cnt        <= '0;
      word_cnt        <= '0;
      timer           <= '0;
      acc             <= '0;
      in_data         <= '0;
      nonce           <= '0;
      tx_cnt          <= '0;
    end else begin
      start_found     <= restart;
      shift_in_enable <= word_done;
      sol_response    <= send_done;
      if (restart) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        timer    <= '0;
        acc      <= '0;
      end else if (state == LOAD) begin
        if (rx_fire) begin
          acc      <= {acc[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          timer    <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
        // word_cnt counts the pulse being launched, so it reads 24 in WAIT_SOL.
        if (word_done) begin
          in_data  <= {acc[23:0], rx_data};
          word_cnt <= word_cnt + 5'd1;
        end
      end
      if (capture) begin
        nonce  <= nonce_in;
        tx_cnt <= '0;
      end else if (tx_fire) begin
        tx_cnt <= tx_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
      case (tx_cnt)
        2'd0:    tx_data = nonce[31:24];
        2'd1:    tx_data = nonce[23:16];
        2'd2:    tx_data = nonce[15:8];
        default: tx_data = nonce[7:0];
      endcase
    end
  end

endmodule

// File: doc/work_loader.md
WORK_LOADER -- requirements
Module: work_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1048576, the LOAD-state inter-byte timeout in clk cycles.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_data, input, 8, host byte.
REQ-005 SHALL have port rx_valid, input, 1, rx_data valid; a byte transfers on a cycle with rx_valid && rx_ready.
REQ-006 SHALL have port rx_ready, output, 1, byte accept.
REQ-007 SHALL have port start_found, output, 1, one-cycle new-work pulse to the mining core.
REQ-008 SHALL have port in_data, output, 32, assembled work word.
REQ-009 SHALL have port shift_in_enable, output, 1, one-cycle pulse qualifying in_data.
REQ-010 SHALL have port sol_claim, input, 1, core reports a golden nonce.
REQ-011 SHALL have port nonce_in, input, 32, golden nonce from the core, valid while sol_claim is high.
REQ-012 SHALL have port sol_response, output, 1, one-cycle acknowledge to the core.
REQ-013 SHALL have port tx_data, output, 8, nonce byte to host.
REQ-014 SHALL have port tx_valid, output, 1, tx_data valid; a byte transfers on a cycle with tx_valid && tx_ready.
REQ-015 SHALL have port tx_ready, input, 1, host accepts the byte.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL implement four states: IDLE, LOAD, WAIT_SOL and SEND.
REQ-018 SHALL drive rx_ready high in IDLE, LOAD and WAIT_SOL, and low in SEND.
REQ-019 In IDLE, SHALL discard every accepted byte except 0xA5 (sync).
REQ-020 On an accepted sync byte in IDLE, SHALL pulse start_found the next cycle, clear the byte and word counters, and enter LOAD.
REQ-021 In LOAD, SHALL shift accepted bytes MSB-first into a 32-bit accumulator.
REQ-022 On every 4th accepted byte, SHALL register the word onto in_data and pulse shift_in_enable the next cycle.
REQ-023 SHALL increment word_cnt on each shift_in_enable pulse.
REQ-024 SHALL treat the first 8 words as midstate and words 9-24 as header; 24 words (96 bytes) make a frame.
REQ-025 SHALL enter WAIT_SOL on the cycle it pulses the 24th shift_in_enable.
REQ-026 SHALL hold in_data stable between shift_in_enable pulses; 0xA5 payload bytes SHALL receive no special treatment in LOAD.
REQ-027 SHALL reset an inter-byte timer on every accepted byte in LOAD.
REQ-028 When the timer reaches TIMEOUT_CYCLES, SHALL return to IDLE with no start_found or shift_in_enable pulse.
REQ-029 In WAIT_SOL, an accepted sync byte SHALL restart the flow exactly as in REQ-020 (new work aborts old).
REQ-030 In WAIT_SOL, when sol_claim is high, SHALL capture nonce_in into a holding register and enter SEND the next cycle.
REQ-031 If sol_claim and an accepted sync byte occur on the same cycle in WAIT_SOL, sol_claim SHALL win and the sync byte SHALL be discarded.
REQ-032 In SEND, SHALL present the captured nonce MSB byte first on tx_data with tx_valid high.
REQ-033 In SEND, SHALL advance to the next byte only on a cycle with tx_valid && tx_ready, and tx_data SHALL be stable while tx_ready is low.
REQ-034 After the 4th byte transfers, SHALL drop tx_valid, pulse sol_response for exactly one cycle, and enter IDLE.
REQ-035 SHALL ignore sol_claim outside WAIT_SOL.
REQ-036 SHALL never assert start_found and shift_in_enable on the same cycle.
REQ-037 SHALL space shift_in_enable pulses at least 4 cycles apart.

Reset
REQ-038 While n_rst is low, SHALL asynchronously force state IDLE, all counters, the timer, in_data, the accumulator and the nonce register to 0.
REQ-039 While n_rst is low, SHALL hold start_found, shift_in_enable, sol_response, tx_valid, busy and tx_data at 0, and rx_ready at 1 (IDLE).
REQ-040 Reset asserted mid-LOAD or mid-SEND SHALL abandon the frame or nonce with no further pulses; the next frame SHALL require a fresh sync byte.

Verification
REQ-041 Bench: sync 0xA5 plus bytes 0x00..0x5F back-to-back -> one start_found; 24 shift_in_enable pulses, the first with in_data=0x00010203 and the last with 0x5C5D5E5F; busy=1; state WAIT_SOL.
REQ-042 Bench: in WAIT_SOL, sol_claim with nonce_in=0xDEADBEEF and tx_ready toggling -> tx bytes DE, AD, BE, EF in order, each held while tx_ready is low; one sol_response pulse; busy returns to 0.
REQ-043 Bench: in IDLE, bytes 0x11, 0x22 before sync -> discarded; no pulses until 0xA5 is accepted.
REQ-044 Bench: LOAD with 10 bytes accepted, then idle for TIMEOUT_CYCLES (set to 16) -> return to IDLE; exactly 2 shift_in_enable pulses were issued.
REQ-045 Bench: in WAIT_SOL, sync byte and sol_claim on the same cycle -> SEND entered, no start_found; a separate sync in WAIT_SOL without sol_claim -> start_found and word_cnt cleared.
REQ-046 Bench: n_rst pulsed low during the 2nd nonce byte -> tx_valid=0 immediately, no sol_response; state IDLE.
